lsu_mem_if: RTL and testbench
=============================

Name: lsu_mem_if

Overview:
- Load/store unit between the execute stage and the word-addressed data memory (32-bit words, combinational read, synchronous write).
- Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Performs read-modify-write for sub-word stores and sign/zero-extends sub-word loads.
- Detects misaligned and out-of-range accesses; reports the result back to the pipeline with a valid/ready request and one-cycle response pulse.

Parameters:
- DEPTH, 32, number of 32-bit words in data memory; word index >= DEPTH is out of range.
- AW, 32, width of byte address and of mem_addr.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- req_unsigned  in  1  zero-extend load (LBU/LHU); ignored for word and stores.
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned/illegal-size/out-of-range; qualified by resp_valid.
- mem_addr  out  AW  word index to data memory (req_addr >> 2).
- mem_wdata  out  32  full word to write.
- mem_we  out  1  memory write enable.
- mem_rdata  in  32  combinational read data for mem_addr.
- perf_loads, perf_stores, perf_errs  out  16 each  see Optional Feature.

Behaviour:
- States: IDLE, LOAD, STRD (store read), STWR (store write), RESP.
- Reset (synchronous, high at rising edge) -> IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0, internal regs cleared, perf counters 0.
- Handshake: accept on req_valid && req_ready; latch we/size/unsigned/addr/wdata. req_ready=0 in every state except IDLE.
- Error check at accept, any one sets err:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - (addr>>2) >= DEPTH.
  - On err: next state RESP directly, mem_we never asserted, resp_rdata=0, resp_err=1.
- Load: IDLE -> LOAD -> RESP.
  - In LOAD, mem_addr=word index; capture mem_rdata.
  - Select byte lane addr[1:0] or half lane addr[1]; sign-extend unless req_unsigned.
  - resp_valid is high 2 cycles after the accept edge.
- Word store: IDLE -> STWR -> RESP. In STWR: mem_we=1, mem_wdata=req_wdata.
- Sub-word store: IDLE -> STRD -> STWR -> RESP.
  - STRD captures mem_rdata into a merge register.
  - STWR writes the merged word: only the addressed byte/half replaced, other bytes unchanged. mem_we=1 for exactly one cycle.
- RESP: resp_valid=1 for one cycle, then IDLE. No response backpressure.
  - Next request can be accepted the cycle after RESP.
- mem_we is high only in STWR and is gated by !reset combinationally: reset asserted during STWR produces no write.
- Reset mid-operation: any state -> IDLE; the in-flight request is dropped with no response.
- mem_addr is held at the latched word index in LOAD/STRD/STWR; in IDLE/RESP it holds its previous value.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- Defined:
  - perf_loads increments in RESP for a load without err.
  - perf_stores increments in RESP for a store without err.
  - perf_errs increments in RESP when err=1.
  - All three are 16-bit, saturate at 0xFFFF, and clear on reset.
- Undefined: ports remain, tied to 0, no counter logic.

Test Plan:
- Memory model word 5 = 0x8000FF7F:
  - LB 0x14 -> resp_rdata=0x0000007F.
  - LB 0x15 -> 0xFFFFFFFF.
  - LBU 0x15 -> 0x000000FF.
  - LH 0x16 -> 0xFFFF8000.
  - LHU 0x16 -> 0x00008000.
  - Each load: resp_valid 2 cycles after accept, resp_err=0.
- SB wdata=0x123456AB addr 0x15 on word 5=0x8000FF7F:
  - STRD then STWR with mem_we=1, mem_addr=5, mem_wdata=0x8000AB7F.
  - resp_valid 3 cycles after accept.
  - Follow-up LW 0x14 -> 0x8000AB7F.
- SW 0xDEADBEEF addr 0x20: one mem_we cycle, mem_addr=8, mem_wdata=0xDEADBEEF; resp_valid 2 cycles after accept.
- Errors, each -> resp_err=1, resp_rdata=0, mem_we never high, resp_valid 1 cycle after accept:
  - LW 0x16;
  - SH 0x13;
  - size=11;
  - LW 0x80 with DEPTH=32.
- Reset high in STWR cycle of SH 0x10: no mem_we edge, word 4 unchanged, state IDLE, req_ready=1 next cycle, no resp_valid.
- With LSU_PERF_CNT_EN: run 3 loads, 2 stores, 1 misaligned -> perf_loads=3, perf_stores=2, perf_errs=1. Without the macro, all three read 0.

Source files
------------

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit between the execute stage and a word-addressed
// data memory (32-bit words, combinational read, synchronous write).
// Byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests become word accesses.
// Sub-word stores use read-modify-write. Sub-word loads are sign- or zero-extended.
// Optional feature macro: LSU_PERF_CNT_EN enables saturating 16-bit
// performance counters. When undefined, the perf ports are tied to 0.
//
// Handshake: a request is accepted on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE. The request fields are sampled at that edge.
// There is no response backpressure: resp_valid is a one-cycle pulse in RESP,
// and resp_rdata/resp_err are meaningful only while resp_valid is high.
module lsu_mem_if #(
  parameter int DEPTH = 32,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata,
  output logic [15:0]   perf_loads,
  output logic [15:0]   perf_stores,
  output logic [15:0]   perf_errs,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_STRD = 3'd2,
    ST_STWR = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t        st, st_nxt;
  logic          accept;
  logic [AW-1:0] req_word;
  logic          req_err;

  // Request fields latched at accept.
  logic          lat_we;
  logic [1:0]    lat_size;
  logic          lat_unsigned;
  logic [1:0]    lat_lane;
  logic [31:0]   lat_wdata;
  logic          lat_err;
  // Holds the extended load data in LOAD, or the merged store word in STRD.
  logic [31:0]   data_q;
  logic [AW-1:0] mem_addr_q;

  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [31:0]   load_ext;
  logic [31:0]   merged;

  assign req_ready = (st == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign req_word  = req_addr >> 2;

  // Request error check: illegal size, misalignment, or word index outside the memory.
  always_comb begin
    req_err = 1'b0;
    if (req_size == SZ_ILL)                            req_err = 1'b1;
    if ((req_size == SZ_HALF) && req_addr[0])          req_err = 1'b1;
    if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
    if (req_word >= AW'(DEPTH))                        req_err = 1'b1;
  end

  // State register. Reset drops any in-flight request without a response.
  always_ff @(posedge clk) begin
    if (reset) st <= ST_IDLE;
    else       st <= st_nxt;
  end

  // Next-state logic. Word stores skip the read phase. Errors go straight to RESP.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                   st_nxt = ST_RESP;
          else if (!req_we)              st_nxt = ST_LOAD;
          else if (req_size == SZ_WORD)  st_nxt = ST_STWR;
          else                           st_nxt = ST_STRD;
        end
      end
      ST_LOAD: st_nxt = ST_RESP;
      ST_STRD: st_nxt = ST_STWR;
      ST_STWR: st_nxt = ST_RESP;
      ST_RESP: st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  // Lane selection and extension of the word read from memory, for loads.
  always_comb begin
    sel_byte = mem_rdata[7:0];
    case (lat_lane)
      2'd0: sel_byte = mem_rdata[7:0];
      2'd1: sel_byte = mem_rdata[15:8];
      2'd2: sel_byte = mem_rdata[23:16];
      2'd3: sel_byte = mem_rdata[31:24];
      default: sel_byte = mem_rdata[7:0];
    endcase
    sel_half = lat_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext = mem_rdata;
    case (lat_size)
      SZ_BYTE: load_ext = lat_unsigned ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      SZ_HALF: load_ext = lat_unsigned ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Merge store data into the word read from memory. Only the addressed lane changes.
  always_comb begin
    merged = mem_rdata;
    case (lat_size)
      SZ_BYTE: begin
        case (lat_lane)
          2'd0: merged[7:0]   = lat_wdata[7:0];
          2'd1: merged[15:8]  = lat_wdata[7:0];
          2'd2: merged[23:16] = lat_wdata[7:0];
          2'd3: merged[31:24] = lat_wdata[7:0];
          default: merged = mem_rdata;
        endcase
      end
      SZ_HALF: begin
        if (lat_lane[1]) merged[31:16] = lat_wdata[15:0];
        else             merged[15:0]  = lat_wdata[15:0];
      end
      default: merged = lat_wdata;
    endcase
  end

  // Datapath registers. Latch the request at accept, then capture memory data in LOAD or STRD.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_lane     <= 2'b00;
      lat_wdata    <= 32'd0;
      lat_err      <= 1'b0;
      data_q       <= 32'd0;
      mem_addr_q   <= '0;
    end else begin
      if (accept) begin
        lat_we       <= req_we;
        lat_size     <= req_size;
        lat_unsigned <= req_unsigned;
        lat_lane     <= req_addr[1:0];
        lat_wdata    <= req_wdata;
        lat_err      <= req_err;
        // An erroring request never drives memory, so mem_addr keeps its old value.
        if (!req_err) mem_addr_q <= req_word;
      end
      if (st == ST_LOAD) data_q <= load_ext;
      if (st == ST_STRD) data_q <= merged;
    end
  end

  assign mem_addr   = mem_addr_q;
  // The write enable is gated by reset so that a reset landing in STWR blocks the write.
  assign mem_we     = (st == ST_STWR) && !reset;
  assign mem_wdata  = (st == ST_STWR) ? ((lat_size == SZ_WORD) ? lat_wdata : data_q) : 32'd0;
  assign resp_valid = (st == ST_RESP);
  assign resp_err   = resp_valid && lat_err;
  assign resp_rdata = (resp_valid && !lat_we && !lat_err) ? data_q : 32'd0;
  assign state_dbg  = st;

`ifdef LSU_PERF_CNT_EN
  logic [15:0] cnt_loads, cnt_stores, cnt_errs;

  // Saturating completion counters, updated once per response.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_loads  <= 16'd0;
      cnt_stores <= 16'd0;
      cnt_errs   <= 16'd0;
    end else if (st == ST_RESP) begin
      if (lat_err) begin
        if (cnt_errs != 16'hFFFF) cnt_errs <= cnt_errs + 16'd1;
      end else if (lat_we) begin
        if (cnt_stores != 16'hFFFF) cnt_stores <= cnt_stores + 16'd1;
      end else begin
        if (cnt_loads != 16'hFFFF) cnt_loads <= cnt_loads + 16'd1;
      end
    end
  end

  assign perf_loads  = cnt_loads;
  assign perf_stores = cnt_stores;
  assign perf_errs   = cnt_errs;
`else
  assign perf_loads  = 16'd0;
  assign perf_stores = 16'd0;
  assign perf_errs   = 16'd0;
`endif

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed testbench for lsu_mem_if with a behavioural word memory.
module tb_lsu_mem_if;

  localparam int DEPTH = 32;
  localparam int AW    = 32;

  // Clock and reset.
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid, resp_err, mem_we;
  logic [31:0]   resp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [15:0]   perf_loads, perf_stores, perf_errs;
  logic [2:0]    state_dbg;

  lsu_mem_if #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_errs(perf_errs),
    .state_dbg(state_dbg)
  );

  // Behavioural memory: combinational read, synchronous write, write monitor.
  logic [31:0] mem [0:DEPTH-1];
  int          we_count = 0;
  logic [31:0] last_waddr = 32'd0;
  logic [31:0] last_wdata = 32'd0;

  assign mem_rdata = (mem_addr < 32'(DEPTH)) ? mem[mem_addr[4:0]] : 32'd0;

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_addr < 32'(DEPTH)) mem[mem_addr[4:0]] <= mem_wdata;
      we_count   <= we_count + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
  end

  // Scoreboard.
  logic [31:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Driver: issue one request, measure latency to resp_valid, and check the response and write count.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_writes);
    int w0;
    int lat;
    logic got;
    logic [31:0] exp_d;
    exp_q.push_back(exp_rdata);
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    w0 = we_count;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    exp_d = exp_q.pop_front();
    check({tag, "_got_resp"}, {31'd0, got}, 32'd1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rdata"}, resp_rdata, exp_d);
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    @(negedge clk);
    check({tag, "_writes"}, we_count - w0, exp_writes);
  endtask

  // Directed test sequence.
  initial begin
    int w_rst;
    logic saw_resp;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    mem[4] = 32'h11223344;
    mem[5] = 32'h8000FF7F;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    check("rst_perf", {perf_loads, perf_stores | perf_errs}, 32'd0);
    reset = 1'b0;

    // Loads on word 5 = 0x8000FF7F.
    do_req("lb_14",  1'b0, 2'b00, 1'b0, 32'h14, 32'd0, 32'h0000007F, 1'b0, 2, 0);
    do_req("lb_15",  1'b0, 2'b00, 1'b0, 32'h15, 32'd0, 32'hFFFFFFFF, 1'b0, 2, 0);
    do_req("lbu_15", 1'b0, 2'b00, 1'b1, 32'h15, 32'd0, 32'h000000FF, 1'b0, 2, 0);
    do_req("lh_16",  1'b0, 2'b01, 1'b0, 32'h16, 32'd0, 32'hFFFF8000, 1'b0, 2, 0);
    do_req("lhu_16", 1'b0, 2'b01, 1'b1, 32'h16, 32'd0, 32'h00008000, 1'b0, 2, 0);

    // Sub-word store with read-modify-write.
    do_req("sb_15", 1'b1, 2'b00, 1'b0, 32'h15, 32'h123456AB, 32'd0, 1'b0, 3, 1);
    check("sb_waddr", last_waddr, 32'd5);
    check("sb_wdata", last_wdata, 32'h8000AB7F);
    do_req("lw_14", 1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 32'h8000AB7F, 1'b0, 2, 0);

    // Word store.
    do_req("sw_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1);
    check("sw_waddr", last_waddr, 32'd8);
    check("sw_wdata", last_wdata, 32'hDEADBEEF);
    check("sw_mem8", mem[8], 32'hDEADBEEF);

    // Error cases: misaligned, illegal size, out of range.
    do_req("err_lw_16", 1'b0, 2'b10, 1'b0, 32'h16, 32'd0, 32'd0, 1'b1, 1, 0);
    do_req("err_sh_13", 1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF, 32'd0, 1'b1, 1, 0);
    do_req("err_size3", 1'b0, 2'b11, 1'b0, 32'h00, 32'd0, 32'd0, 1'b1, 1, 0);
    do_req("err_lw_80", 1'b0, 2'b10, 1'b0, 32'h80, 32'd0, 32'd0, 1'b1, 1, 0);
    check("err_mem_addr_held", mem_addr, 32'd8);

    // Reset asserted during STWR of SH 0x10 must block the write and drop the response.
    w_rst = we_count;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstwr_state_strd", {29'd0, state_dbg}, 32'd2);
    @(negedge clk);
    check("rstwr_state_stwr", {29'd0, state_dbg}, 32'd3);
    reset = 1'b1;
    #1;
    check("rstwr_mem_we_gated", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rstwr_state_idle", {29'd0, state_dbg}, 32'd0);
    check("rstwr_ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b0;
    saw_resp = resp_valid;
    repeat (3) begin
      @(negedge clk);
      saw_resp = saw_resp | resp_valid;
    end
    check("rstwr_no_resp", {31'd0, saw_resp}, 32'd0);
    check("rstwr_no_write", we_count - w_rst, 32'd0);
    check("rstwr_word4", mem[4], 32'h11223344);
    check("rstwr_perf_clear", {perf_loads, perf_stores | perf_errs}, 32'd0);

    // Counter run after reset: 3 loads, 2 stores, 1 misaligned access.
    do_req("p_lb_14",  1'b0, 2'b00, 1'b0, 32'h14, 32'd0, 32'h0000007F, 1'b0, 2, 0);
    do_req("p_lbu_15", 1'b0, 2'b00, 1'b1, 32'h15, 32'd0, 32'h000000AB, 1'b0, 2, 0);
    do_req("p_sh_12",  1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 32'd0, 1'b0, 3, 1);
    do_req("p_lw_10",  1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h12343344, 1'b0, 2, 0);
    do_req("p_sw_24",  1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFEF00D, 32'd0, 1'b0, 2, 1);
    do_req("p_lh_15",  1'b0, 2'b01, 1'b0, 32'h15, 32'd0, 32'd0, 1'b1, 1, 0);
`ifdef LSU_PERF_CNT_EN
    check("perf_loads", {16'd0, perf_loads}, 32'd3);
    check("perf_stores", {16'd0, perf_stores}, 32'd2);
    check("perf_errs", {16'd0, perf_errs}, 32'd1);
`else
    check("perf_loads", {16'd0, perf_loads}, 32'd0);
    check("perf_stores", {16'd0, perf_stores}, 32'd0);
    check("perf_errs", {16'd0, perf_errs}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
